audio_level_meter: RTL and testbench



---
 rtl/audio_level_meter.sv | 185 ++++++++++++++++++
 tb/tb_audio_level_meter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_level_meter.sv
// Audio level meter: |sample| -> instant-attack / stepped-decay envelope -> LED segment count,
// with peak-hold marker, stretched clip flag and bar/dot LED decode. Three-stage pipeline.
module audio_level_meter #(
  parameter int DATA_W    = 12,
  parameter int NUM_LEDS  = 9,
  parameter int DECAY_DIV = 256,
  parameter int PEAK_HOLD = 24000,
  parameter int CLIP_HOLD = 12000,
  localparam int LW = $clog2(NUM_LEDS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [DATA_W-1:0]   sample,
  input  logic                mode,
  output logic [NUM_LEDS-1:0] led,
  output logic [LW-1:0]       level,
  output logic [LW-1:0]       peak,
  output logic                clip,
  output logic                level_valid
);

  localparam int MW  = DATA_W - 1;
  localparam int DCW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam int HCW = (PEAK_HOLD > 1) ? $clog2(PEAK_HOLD) : 1;
  localparam int CCW = $clog2(CLIP_HOLD + 1);

  localparam logic [MW-1:0]  MAG_MAX     = {MW{1'b1}};
  localparam logic [DCW-1:0] DC_LAST     = DCW'(DECAY_DIV - 1);
  localparam logic [HCW-1:0] HOLD_RELOAD = HCW'(PEAK_HOLD - 1);
  localparam logic [CCW-1:0] CLIP_LOAD   = CCW'(CLIP_HOLD);

  // Segment thresholds floor(i * 2^(DATA_W-1) / (NUM_LEDS+1)); constant-folded at elaboration
  function automatic logic [MW-1:0] threshold(input int i);
    return MW'((longint'(i) << (DATA_W - 1)) / longint'(NUM_LEDS + 1));
  endfunction

  logic [MW-1:0]  mag_q, mag_d;
  logic           s1_valid_q, s1_valid_d;
  logic [CCW-1:0] clip_cnt_q, clip_cnt_d;
  logic           clip_q, clip_d;
  logic [MW-1:0]  env_q, env_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic           s2_valid_q, s2_valid_d;
  logic [LW-1:0]  level_q, level_d;
  logic [LW-1:0]  peak_q, peak_d;
  logic [HCW-1:0] hold_q, hold_d;
  logic           level_valid_q, level_valid_d;

  logic [MW-1:0]  sample_abs;
  logic           sample_is_min;
  logic           clip_evt;
  logic [MW-1:0]  decay_step;
  logic [LW-1:0]  level_new;

  // Stage 1: magnitude with saturation of the most negative code, clip detect and stretch
  always_comb begin
    sample_is_min = (sample == {1'b1, {MW{1'b0}}});
    clip_evt      = sample_is_min || (sample == {1'b0, MAG_MAX});
    if (sample_is_min) begin
      sample_abs = MAG_MAX;
    end else if (sample[DATA_W-1]) begin
      sample_abs = ~sample[MW-1:0] + MW'(1);
    end else begin
      sample_abs = sample[MW-1:0];
    end

    s1_valid_d = sample_valid;
    mag_d      = mag_q;
    clip_cnt_d = clip_cnt_q;
    if (sample_valid) begin
      mag_d = sample_abs;
      if (clip_evt) begin
        clip_cnt_d = CLIP_LOAD;
      end else if (clip_cnt_q != {CCW{1'b0}}) begin
        clip_cnt_d = clip_cnt_q - CCW'(1);
      end else begin
        clip_cnt_d = clip_cnt_q;
      end
    end else begin
      mag_d = mag_q;
    end
    clip_d = (clip_cnt_d != {CCW{1'b0}});
  end

  // Stage 2: envelope; attack wins over a coincident decay step
  always_comb begin
    decay_step = ((env_q >> 3) == {MW{1'b0}}) ? MW'(1) : (env_q >> 3);
    s2_valid_d = s1_valid_q;
    env_d      = env_q;
    dcnt_d     = dcnt_q;
    if (s1_valid_q) begin
      if (mag_q >= env_q) begin
        env_d  = mag_q;
        dcnt_d = {DCW{1'b0}};
      end else if (dcnt_q == DC_LAST) begin
        dcnt_d = {DCW{1'b0}};
        env_d  = (env_q > decay_step) ? (env_q - decay_step) : {MW{1'b0}};
      end else begin
        dcnt_d = dcnt_q + DCW'(1);
      end
    end else begin
      env_d  = env_q;
      dcnt_d = dcnt_q;
    end
  end

  // Stage 3: quantise envelope to a segment count and run the peak-hold marker
  always_comb begin
    level_new = {LW{1'b0}};
    for (int i = 1; i <= NUM_LEDS; i++) begin
      if (env_q >= threshold(i)) begin
        level_new = level_new + LW'(1);
      end else begin
        level_new = level_new;
      end
    end

    level_valid_d = s2_valid_q;
    level_d       = level_q;
    peak_d        = peak_q;
    hold_d        = hold_q;
    if (s2_valid_q) begin
      level_d = level_new;
      if (level_new >= peak_q) begin
        peak_d = level_new;
        hold_d = HOLD_RELOAD;
      end else if (hold_q == {HCW{1'b0}}) begin
        peak_d = peak_q - LW'(1);
        hold_d = HOLD_RELOAD;
      end else begin
        hold_d = hold_q - HCW'(1);
      end
    end else begin
      level_d = level_q;
    end
  end

  // LED decode stays combinational so a mode change shows in the same cycle
  always_comb begin
    led = {NUM_LEDS{1'b0}};
    for (int k = 0; k < NUM_LEDS; k++) begin
      if (mode) begin
        led[k] = (LW'(k + 1) == level_q) || (LW'(k + 1) == peak_q);
      end else begin
        led[k] = (LW'(k + 1) <= level_q) || (LW'(k + 1) == peak_q);
      end
    end
  end

  // All pipeline state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_q         <= {MW{1'b0}};
      s1_valid_q    <= 1'b0;
      clip_cnt_q    <= {CCW{1'b0}};
      clip_q        <= 1'b0;
      env_q         <= {MW{1'b0}};
      dcnt_q        <= {DCW{1'b0}};
      s2_valid_q    <= 1'b0;
      level_q       <= {LW{1'b0}};
      peak_q        <= {LW{1'b0}};
      hold_q        <= {HCW{1'b0}};
      level_valid_q <= 1'b0;
    end else begin
      mag_q         <= mag_d;
      s1_valid_q    <= s1_valid_d;
      clip_cnt_q    <= clip_cnt_d;
      clip_q        <= clip_d;
      env_q         <= env_d;
      dcnt_q        <= dcnt_d;
      s2_valid_q    <= s2_valid_d;
      level_q       <= level_d;
      peak_q        <= peak_d;
      hold_q        <= hold_d;
      level_valid_q <= level_valid_d;
    end
  end

  assign level       = level_q;
  assign peak        = peak_q;
  assign clip        = clip_q;
  assign level_valid = level_valid_q;

endmodule

// File: tb/tb_audio_level_meter.sv
// Self-checking bench for audio_level_meter: a per-sample reference model (plain integer
// arithmetic) whose results are replayed with the pipeline latency and compared every cycle.
module tb_audio_level_meter;
  localparam int DATA_W    = 12;
  localparam int NUM_LEDS  = 9;
  localparam int DECAY_DIV = 4;
  localparam int PEAK_HOLD = 8;
  localparam int CLIP_HOLD = 4;
  localparam int LW        = $clog2(NUM_LEDS + 1);
  localparam int MAXMAG    = (1 << (DATA_W - 1)) - 1;
  localparam int HMAX      = 4096;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                sample_valid = 1'b0;
  logic [DATA_W-1:0]   sample = '0;
  logic                mode = 1'b0;
  logic [NUM_LEDS-1:0] led;
  logic [LW-1:0]       level;
  logic [LW-1:0]       peak;
  logic                clip;
  logic                level_valid;

  audio_level_meter #(
    .DATA_W(DATA_W), .NUM_LEDS(NUM_LEDS), .DECAY_DIV(DECAY_DIV),
    .PEAK_HOLD(PEAK_HOLD), .CLIP_HOLD(CLIP_HOLD)
  ) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample), .mode(mode),
    .led(led), .level(level), .peak(peak), .clip(clip), .level_valid(level_valid)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 3;
  int o_cyc = 0;
  int h_lvl [HMAX];
  int h_pk  [HMAX];
  int h_v   [HMAX];
  int h_clip[HMAX];
  int m_env, m_dc, m_clip, m_pk, m_hold, m_lvl;

  logic [LW-1:0]       o_lvl, o_pk, e_lvl, e_pk;
  logic                o_v, o_clip, e_v, e_clip;
  logic [NUM_LEDS-1:0] o_led, e_led;

  function automatic int q_level(input int env);
    int n;
    n = 0;
    for (int i = 1; i <= NUM_LEDS; i++)
      if ((i * (MAXMAG + 1)) / (NUM_LEDS + 1) <= env) n++;
    return n;
  endfunction

  function automatic logic [NUM_LEDS-1:0] seg_pattern(input int lvl, input int pk, input logic m);
    logic [NUM_LEDS-1:0] r;
    r = '0;
    for (int k = 1; k <= NUM_LEDS; k++)
      r[k-1] = (m ? (k == lvl) : (k <= lvl)) || (k == pk);
    return r;
  endfunction

  function automatic int pick_sample(input int shift);
    int r;
    r = int'($urandom_range(0, 15));
    if (r == 0) return MAXMAG;
    if (r == 1) return -MAXMAG - 1;
    return (int'($urandom_range(0, 4095)) - 2048) / (1 << shift);
  endfunction

  task automatic model_sample(input int s);
    int mag;
    int step;
    mag = (s < 0) ? -s : s;
    if (mag > MAXMAG) mag = MAXMAG;
    if (s == MAXMAG || s == -MAXMAG - 1) m_clip = CLIP_HOLD;
    else if (m_clip > 0) m_clip--;
    if (mag >= m_env) begin
      m_env = mag;
      m_dc  = 0;
    end else if (m_dc == DECAY_DIV - 1) begin
      m_dc = 0;
      step = m_env / 8;
      if (step < 1) step = 1;
      m_env = (m_env > step) ? m_env - step : 0;
    end else begin
      m_dc++;
    end
    m_lvl = q_level(m_env);
    if (m_lvl >= m_pk) begin
      m_pk = m_lvl;
      m_hold = PEAK_HOLD - 1;
    end else if (m_hold == 0) begin
      m_pk--;
      m_hold = PEAK_HOLD - 1;
    end else begin
      m_hold--;
    end
  endtask

  task automatic model_reset();
    m_env = 0; m_dc = 0; m_clip = 0; m_pk = 0; m_hold = 0; m_lvl = 0;
    for (int j = 1; j <= 3; j++) begin
      h_lvl[cyc-j] = 0; h_pk[cyc-j] = 0; h_v[cyc-j] = 0; h_clip[cyc-j] = 0;
    end
  endtask

  // Observe outputs at the falling edge, derive expectations, then apply this cycle's input
  task automatic drive(input logic v, input int s);
    @(negedge clk);
    if (cyc >= HMAX) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, HMAX);
      $fatal(1, "cycle budget exhausted");
    end
    o_cyc  = cyc;
    o_lvl  = level; o_pk = peak; o_v = level_valid; o_clip = clip; o_led = led;
    e_lvl  = LW'(h_lvl[cyc-3]);
    e_pk   = LW'(h_pk[cyc-3]);
    e_v    = (h_v[cyc-3] != 0);
    e_clip = (h_clip[cyc-1] != 0);
    e_led  = seg_pattern(h_lvl[cyc-3], h_pk[cyc-3], mode);
    sample_valid = v;
    sample = DATA_W'(s);
    if (v && !rst) model_sample(s);
    h_lvl[cyc] = m_lvl; h_pk[cyc] = m_pk; h_clip[cyc] = m_clip;
    h_v[cyc] = (v && !rst) ? 1 : 0;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mode = 1'b0;
    model_reset();
    repeat (4) drive(1'b0, 0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      drive(i < 2, MAXMAG);
      checks++;
      if ({o_lvl, o_pk, o_v, o_clip, o_led} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got lvl=%0d pk=%0d lv=%0b clip=%0b led=%b, expected all zero",
                 o_cyc, o_lvl, o_pk, o_v, o_clip, o_led);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_latency();
    int n;
    n = cyc;
    for (int i = 0; i < 6; i++) begin
      drive(i == 0, 1000);
      checks++;
      if ({o_lvl, o_pk, o_v, o_clip, o_led} !== {e_lvl, e_pk, e_v, e_clip, e_led}) begin
        errors++;
        $display("FAIL latency_stream cyc=%0d got lvl=%0d pk=%0d lv=%0b clip=%0b led=%b, expected lvl=%0d pk=%0d lv=%0b clip=%0b led=%b",
                 o_cyc, o_lvl, o_pk, o_v, o_clip, o_led, e_lvl, e_pk, e_v, e_clip, e_led);
      end
      if (o_cyc == n + 3) begin
        checks++;
        if (o_lvl !== 4'd4 || o_pk !== 4'd4 || o_led !== 9'b000001111 || o_v !== 1'b1) begin
          errors++;
          $display("FAIL latency_n3 got lvl=%0d pk=%0d led=%b lv=%0b, expected lvl=4 pk=4 led=000001111 lv=1",
                   o_lvl, o_pk, o_led, o_v);
        end
      end else if (o_cyc == n + 2 || o_cyc == n + 4) begin
        checks++;
        if (o_v !== 1'b0) begin
          errors++;
          $display("FAIL latency_strobe_width cyc=%0d got lv=%0b, expected lv=0", o_cyc - n, o_v);
        end
      end
    end
  endtask

  task automatic test_neg_clip();
    int n;
    do_reset();
    n = cyc;
    for (int i = 0; i < 6; i++) begin
      drive(i == 0, -2048);
      checks++;
      if ({o_lvl, o_pk, o_v, o_clip, o_led} !== {e_lvl, e_pk, e_v, e_clip, e_led}) begin
        errors++;
        $display("FAIL negclip_stream cyc=%0d got lvl=%0d pk=%0d lv=%0b clip=%0b led=%b, expected lvl=%0d pk=%0d lv=%0b clip=%0b led=%b",
                 o_cyc, o_lvl, o_pk, o_v, o_clip, o_led, e_lvl, e_pk, e_v, e_clip, e_led);
      end
      if (o_cyc == n || o_cyc == n + 1) begin
        checks++;
        if (o_clip !== (o_cyc == n + 1)) begin
          errors++;
          $display("FAIL negclip_clip_rise at n+%0d got clip=%0b, expected clip=%0b", o_cyc - n, o_clip, o_cyc == n + 1);
        end
      end
      if (o_cyc == n + 3) begin
        checks++;
        if (o_lvl !== 4'd9 || o_led !== 9'h1FF) begin
          errors++;
          $display("FAIL negclip_level got lvl=%0d led=%b, expected lvl=9 led=111111111", o_lvl, o_led);
        end
      end
    end
  endtask

  task automatic test_decay();
    int n;
    int want_l;
    int want_p;
    do_reset();
    n = cyc;
    for (int i = 0; i <= 40; i++) begin
      drive(1'b1, (i == 0) ? MAXMAG : 0);
      checks++;
      if ({o_lvl, o_pk, o_v, o_clip, o_led} !== {e_lvl, e_pk, e_v, e_clip, e_led}) begin
        errors++;
        $display("FAIL decay_stream cyc=%0d got lvl=%0d pk=%0d lv=%0b clip=%0b led=%b, expected lvl=%0d pk=%0d lv=%0b clip=%0b led=%b",
                 o_cyc, o_lvl, o_pk, o_v, o_clip, o_led, e_lvl, e_pk, e_v, e_clip, e_led);
      end
      want_l = -1;
      want_p = -1;
      case (o_cyc - n)
        6:       want_l = 9;
        7:       want_l = 8;
        10:      want_l = 8;
        11:      begin want_l = 7; want_p = 9; end
        13:      want_p = 9;
        14:      want_p = 8;
        21:      want_p = 8;
        22:      want_p = 7;
        default: want_l = -1;
      endcase
      if (want_l >= 0) begin
        checks++;
        if (o_lvl !== LW'(want_l)) begin
          errors++;
          $display("FAIL decay_level at n+%0d got lvl=%0d, expected lvl=%0d", o_cyc - n, o_lvl, want_l);
        end
      end
      if (want_p >= 0) begin
        checks++;
        if (o_pk !== LW'(want_p)) begin
          errors++;
          $display("FAIL decay_peak at n+%0d got pk=%0d, expected pk=%0d", o_cyc - n, o_pk, want_p);
        end
      end
    end
  endtask

  task automatic test_clip_stretch();
    int seq[17] = '{2047, 100, 100, 100, 100, 100, -2048, 50, 50, -2048, 50, 50, 50, 50, 50, 0, 0};
    int n;
    int want;
    do_reset();
    n = cyc;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, seq[i]);
      checks++;
      if ({o_lvl, o_pk, o_v, o_clip, o_led} !== {e_lvl, e_pk, e_v, e_clip, e_led}) begin
        errors++;
        $display("FAIL clip_stream cyc=%0d got lvl=%0d pk=%0d lv=%0b clip=%0b led=%b, expected lvl=%0d pk=%0d lv=%0b clip=%0b led=%b",
                 o_cyc, o_lvl, o_pk, o_v, o_clip, o_led, e_lvl, e_pk, e_v, e_clip, e_led);
      end
      case (o_cyc - n)
        1, 4, 11, 13: want = 1;
        0, 5, 14:     want = 0;
        default:      want = -1;
      endcase
      if (want >= 0) begin
        checks++;
        if (o_clip !== want[0]) begin
          errors++;
          $display("FAIL clip_window at n+%0d got clip=%0b, expected clip=%0d", o_cyc - n, o_clip, want);
        end
      end
    end
  endtask

  task automatic test_dot_mode();
    do_reset();
    for (int i = 0; i < 13; i++) begin
      drive(i < 9, (i == 0) ? MAXMAG : 0);
      checks++;
      if ({o_lvl, o_pk, o_v, o_clip, o_led} !== {e_lvl, e_pk, e_v, e_clip, e_led}) begin
        errors++;
        $display("FAIL dot_stream cyc=%0d got lvl=%0d pk=%0d lv=%0b clip=%0b led=%b, expected lvl=%0d pk=%0d lv=%0b clip=%0b led=%b",
                 o_cyc, o_lvl, o_pk, o_v, o_clip, o_led, e_lvl, e_pk, e_v, e_clip, e_led);
      end
    end
    mode = 1'b1;
    #1;
    checks++;
    if (level !== 4'd7 || peak !== 4'd9 || led !== 9'h140) begin
      errors++;
      $display("FAIL dot_pattern got lvl=%0d pk=%0d led=%b, expected lvl=7 pk=9 led=101000000", level, peak, led);
    end
    mode = 1'b0;
    #1;
    checks++;
    if (led !== 9'h17F) begin
      errors++;
      $display("FAIL bar_pattern got led=%b, expected led=101111111", led);
    end
  endtask

  task automatic test_back_to_back();
    int shift;
    logic v;
    shift = 0;
    for (int i = 0; i < 240; i++) begin
      if (i % 24 == 0) shift = int'($urandom_range(0, 11));
      if (i % 7 == 0) mode = 1'($urandom_range(0, 1));
      drive(1'b1, pick_sample(shift));
      checks++;
      if ({o_lvl, o_pk, o_v, o_clip, o_led} !== {e_lvl, e_pk, e_v, e_clip, e_led}) begin
        errors++;
        $display("FAIL b2b_stream cyc=%0d got lvl=%0d pk=%0d lv=%0b clip=%0b led=%b, expected lvl=%0d pk=%0d lv=%0b clip=%0b led=%b",
                 o_cyc, o_lvl, o_pk, o_v, o_clip, o_led, e_lvl, e_pk, e_v, e_clip, e_led);
      end
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({level, peak, led, clip, level_valid} !== '0) begin
      errors++;
      $display("FAIL async_reset got lvl=%0d pk=%0d led=%b clip=%0b lv=%0b, expected all zero",
               level, peak, led, clip, level_valid);
    end
    model_reset();
    drive(1'b1, MAXMAG);
    drive(1'b1, MAXMAG);
    drive(1'b0, 0);
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (i % 30 == 0) shift = int'($urandom_range(0, 11));
      if (i % 11 == 0) mode = 1'($urandom_range(0, 1));
      v = ($urandom_range(0, 3) != 0);
      drive(v, pick_sample(shift));
      checks++;
      if ({o_lvl, o_pk, o_v, o_clip, o_led} !== {e_lvl, e_pk, e_v, e_clip, e_led}) begin
        errors++;
        $display("FAIL gap_stream cyc=%0d got lvl=%0d pk=%0d lv=%0b clip=%0b led=%b, expected lvl=%0d pk=%0d lv=%0b clip=%0b led=%b",
                 o_cyc, o_lvl, o_pk, o_v, o_clip, o_led, e_lvl, e_pk, e_v, e_clip, e_led);
      end
      if (i < 3) begin
        checks++;
        if (o_v !== 1'b0) begin
          errors++;
          $display("FAIL stale_valid %0d cycles after release got lv=%0b, expected lv=0", i, o_v);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_neg_clip();
    test_decay();
    test_clip_stretch();
    test_dot_mode();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
